led_mode_ctrl: RTL and testbench
================================

// Module: led_mode_ctrl
// PURPOSE
//   Board-level controller for the 8-bit LED bank, driven by five push buttons.
//   - Debounces each button and turns every press into exactly one event.
//   - Sequences the LEDs through four display modes (static, shift, blink, count).
//   - Sets the display update rate from the up/down buttons.
//   Sits between the raw board pins (btn*) and the led outputs; top-level instance.
// PARAMETERS
//   LED_W           8            LED bank width (>=2)
//   DEBOUNCE_CYCLES 10           consecutive high cycles before a press is accepted (>=1)
//   TICK_DIV        100_000_000  base update period in clk cycles at speed 0 (>=8)
//   REPEAT_CYCLES   50_000_000   auto-repeat interval (used only with BTN_REPEAT_EN)
// PORTS
//   clk     in   1      system clock
//   rst_n   in   1      asynchronous active-low reset
//   btnC    in   1      raw button: next mode
//   btnU    in   1      raw button: speed up
//   btnD    in   1      raw button: speed down
//   btnL    in   1      raw button: mode-specific action L
//   btnR    in   1      raw button: mode-specific action R
//   led     out  LED_W  registered LED drive
//   mode    out  2      current mode: 0 STATIC, 1 SHIFT, 2 BLINK, 3 COUNT
// BEHAVIOUR
//   Reset (async assert, sync release; all outputs 0)
//     mode=0, led=0, pattern=1, count=0, speed=0, dir=left, blink_ph=0.
//     All debounce counters and the prescaler clear.
//     Reset mid-press: the held button must be released before it can fire again.
//   Per-button front end
//     - 2-FF synchroniser, then a saturating counter: +1 while synced high, 0 when low.
//     - press pulse (1 cycle) when the counter steps DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES.
//     - Pulse lands 2+DEBOUNCE_CYCLES edges after the raw input rises; one pulse per press.
//     - A glitch shorter than DEBOUNCE_CYCLES yields no pulse.
//   Event handling (on the edge after the press pulse)
//     - Priority btnC > btnU/btnD > btnL/btnR; same-cycle lower-priority events are dropped.
//     - btnC: mode <= mode+1, wrapping 3 -> 0. Prescaler and blink_ph clear.
//     - btnU: speed <= min(speed+1, 3). btnD: speed <= max(speed-1, 0).
//       btnU and btnD in the same cycle: no change.
//       Any effective speed change clears the prescaler.
//     - STATIC: btnL rotates pattern left by 1; btnR toggles pattern[0].
//     - SHIFT:  btnL sets dir=left; btnR sets dir=right.
//     - BLINK:  btnL, btnR ignored.
//     - COUNT:  btnR clears count; btnL ignored.
//   Prescaler
//     - Counts 0..(TICK_DIV>>speed)-1; tick pulses for 1 cycle on wrap.
//     - First tick comes TICK_DIV>>speed cycles after reset, mode change or speed change.
//     - A tick coinciding with a button event: the event wins, the tick is dropped.
//   Tick actions
//     - SHIFT: rotate pattern by 1 in dir; MSB<->LSB wrap-around.
//     - BLINK: toggle blink_ph.
//     - COUNT: count <= count+1 mod 2^LED_W.
//     - STATIC: no action.
//   Output mux (led registered, one edge after the state update)
//     - STATIC, SHIFT: led = pattern.
//     - BLINK: led = blink_ph ? 0 : pattern.
//     - COUNT: led = count.
//   Pattern and count persist across mode changes.
// CONFIGURATION
//   BTN_REPEAT_EN defined:
//     - btnL/btnR held past DEBOUNCE_CYCLES emit a further press pulse every
//       REPEAT_CYCLES cycles while still held. Repeat timer restarts on each pulse.
//     - btnC, btnU, btnD never repeat.
//   BTN_REPEAT_EN undefined:
//     - Exactly one pulse per press for every button; REPEAT_CYCLES unused.
// TESTING  (DEBOUNCE_CYCLES=4, TICK_DIV=16, REPEAT_CYCLES=8)
//   1. Reset, then btnC high 3 cycles -> no pulse; mode=0, led=0x00 stays.
//   2. btnC held 20 cycles -> exactly one mode change to 1; led=0x01, rotating left
//      every 16 cycles: 0x02, 0x04 ... 0x80, then wrap to 0x01.
//   3. SHIFT, btnR press -> next tick gives 0x80 from 0x01.
//      Then btnU x5 -> speed saturates at 3, tick every 2 cycles.
//   4. Mode 3 (COUNT), speed 3 -> led increments every 2 cycles, 0xFF wraps to 0x00.
//      btnR press -> led=0x00 on the next edge after the event.
//   5. btnC and btnR asserted together -> only the mode advances; pattern unchanged.
//      rst_n pulsed low mid-count -> led=0, mode=0 immediately (async).
//   6. BTN_REPEAT_EN, STATIC, btnL held 40 cycles -> pattern rotates 1 + 4 times.
//      Without the macro -> rotates once.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: five-button LED bank controller.
// Debounced button events select one of four display modes (static, shift,
// blink, count) and the update rate. Define BTN_REPEAT_EN to make held
// btnL/btnR auto-repeat every REPEAT_CYCLES cycles.
// rst_n is expected to be released synchronously to clk by the board reset
// generator; assertion may be fully asynchronous.

// Per-button front end: synchroniser, saturating debounce counter, press pulse.
module led_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int REPEAT_CYCLES   = 50_000_000,
    parameter bit REPEAT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          armed_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] rep_q;
    logic          sync;
    logic          held;
    logic          first_fire;
    logic          rep_fire;

    assign sync       = sync_q[1];
    assign held       = sync && (cnt_q == CNT_MAX);
    assign first_fire = sync && armed_q && (cnt_q == CNT_FIRE);
    assign rep_fire   = REPEAT && held && (rep_q == REP_LAST);

    // Two-flop synchroniser; resets to "pressed" so a button held through
    // reset reads high until it is actually released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn};
    end

    // Counting is only enabled once the button has been seen released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     armed_q <= 1'b0;
        else if (!sync) armed_q <= 1'b1;
    end

    // Saturating debounce counter, cleared whenever the input reads low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt_q <= '0;
        else if (!sync || !armed_q) cnt_q <= '0;
        else if (cnt_q != CNT_MAX)  cnt_q <= cnt_q + CW'(1);
    end

    // Auto-repeat timer runs only while saturated and restarts on each pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         rep_q <= '0;
        else if (!REPEAT || !held || rep_fire) rep_q <= '0;
        else                                rep_q <= rep_q + RW'(1);
    end

    // One-cycle registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) press <= 1'b0;
        else        press <= first_fire || rep_fire;
    end
endmodule

module led_mode_ctrl #(
    parameter int LED_W           = 8,
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int TICK_DIV        = 100_000_000,
    parameter int REPEAT_CYCLES   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btnC,
    input  logic             btnU,
    input  logic             btnD,
    input  logic             btnL,
    input  logic             btnR,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode
);
    localparam int NUM_BTN = 5;
    localparam int PW      = $clog2(TICK_DIV);

    // Button index order: {R, L, D, U, C}; only L and R may auto-repeat.
`ifdef BTN_REPEAT_EN
    localparam logic [NUM_BTN-1:0] REPEAT_MASK = 5'b11000;
`else
    localparam logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00000;
`endif

    typedef enum logic [1:0] {M_STATIC, M_SHIFT, M_BLINK, M_COUNT} mode_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;
    logic ev_c, ev_u, ev_d, ev_l, ev_r;

    mode_t            mode_q, mode_d;
    logic [LED_W-1:0] pattern_q, pattern_d;
    logic [LED_W-1:0] count_q, count_d;
    logic [1:0]       speed_q, speed_d;
    logic             dir_q, dir_d;        // 0 = left, 1 = right
    logic             blink_q, blink_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             upd_q, upd_d;        // state changed: reload led next edge
    logic [PW-1:0]    presc_last;
    logic             tick;
    logic [LED_W-1:0] rot_l, rot_r, led_mux;

    assign btn_raw = {btnR, btnL, btnD, btnU, btnC};
    assign {ev_r, ev_l, ev_d, ev_u, ev_c} = press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        led_btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT          (REPEAT_MASK[i])
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .press (press[i])
        );
    end

    assign presc_last = PW'((TICK_DIV >> speed_q) - 1);
    assign tick       = (presc_q == presc_last);
    assign rot_l      = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
    assign rot_r      = {pattern_q[0], pattern_q[LED_W-1:1]};
    assign mode       = mode_q;

    // State register for mode, display state, speed and prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= M_STATIC;
            pattern_q <= LED_W'(1);
            count_q   <= '0;
            speed_q   <= '0;
            dir_q     <= 1'b0;
            blink_q   <= 1'b0;
            presc_q   <= '0;
            upd_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            speed_q   <= speed_d;
            dir_q     <= dir_d;
            blink_q   <= blink_d;
            presc_q   <= presc_d;
            upd_q     <= upd_d;
        end
    end

    // Next state: one prioritised button event per cycle, else a tick action.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        speed_d   = speed_q;
        dir_d     = dir_q;
        blink_d   = blink_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);
        upd_d     = 1'b0;
        if (ev_c) begin
            mode_d  = mode_t'(mode_q + 2'd1);
            presc_d = '0;
            blink_d = 1'b0;
            upd_d   = 1'b1;
        end else if (ev_u || ev_d) begin
            upd_d = 1'b1;
            if (ev_u && !ev_d && speed_q != 2'd3) begin
                speed_d = speed_q + 2'd1;
                presc_d = '0;
            end else if (ev_d && !ev_u && speed_q != 2'd0) begin
                speed_d = speed_q - 2'd1;
                presc_d = '0;
            end
        end else if (ev_l || ev_r) begin
            // Simultaneous L and R: L takes precedence where both act.
            upd_d = 1'b1;
            case (mode_q)
                M_STATIC: pattern_d = ev_l ? rot_l : (pattern_q ^ LED_W'(1));
                M_SHIFT:  dir_d     = ev_l ? 1'b0 : 1'b1;
                M_COUNT:  if (ev_r) count_d = '0;
                default:  ;
            endcase
        end else if (tick) begin
            case (mode_q)
                M_SHIFT: begin
                    pattern_d = dir_q ? rot_r : rot_l;
                    upd_d     = 1'b1;
                end
                M_BLINK: begin
                    blink_d = ~blink_q;
                    upd_d   = 1'b1;
                end
                M_COUNT: begin
                    count_d = count_q + LED_W'(1);
                    upd_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display source for the current mode.
    always_comb begin
        led_mux = pattern_q;
        case (mode_q)
            M_BLINK: led_mux = blink_q ? '0 : pattern_q;
            M_COUNT: led_mux = count_q;
            default: ;
        endcase
    end

    // LED register reloads one edge after any state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     led <= '0;
        else if (upd_q) led <= led_mux;
    end
endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl (DEBOUNCE_CYCLES=4, TICK_DIV=16,
// REPEAT_CYCLES=8). Expected {mode,led} values are queued in order as the
// stimulus is issued; the monitor pops one entry per observed output change.
// Edge numbers below count clock edges after the most recent reset release.
module tb_led_mode_ctrl;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       btnC  = 1'b0;
    logic       btnU  = 1'b0;
    logic       btnD  = 1'b0;
    logic       btnL  = 1'b0;
    logic       btnR  = 1'b0;
    logic [7:0] led;
    logic [1:0] mode;

    led_mode_ctrl #(
        .LED_W           (8),
        .DEBOUNCE_CYCLES (4),
        .TICK_DIV        (16),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btnC  (btnC),
        .btnU  (btnU),
        .btnD  (btnD),
        .btnL  (btnL),
        .btnR  (btnR),
        .led   (led),
        .mode  (mode)
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] expq[$];
    logic       mon_en = 1'b0;
    logic [9:0] prev   = '0;

    // Monitor: every change of {mode, led} must match the next queued entry.
    always @(negedge clk) begin
        logic [9:0] cur;
        logic [9:0] want;
        cur = {mode, led};
        if (mon_en && cur !== prev) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got mode=%0d led=%02h want no change (cyc %0d)",
                         cur[9:8], cur[7:0], cyc - base);
            end else begin
                want = expq.pop_front();
                if (cur !== want) begin
                    errors++;
                    $display("FAIL sb_seq got mode=%0d led=%02h want mode=%0d led=%02h (cyc %0d)",
                             cur[9:8], cur[7:0], want[9:8], want[7:0], cyc - base);
                end
            end
            prev = cur;
        end
    end

    task automatic wait_edge(input int n);
        wait (cyc >= base + n);
        #1;
    endtask

    task automatic exp_push(input logic [1:0] m, input logic [7:0] l);
        expq.push_back({m, l});
    endtask

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %03h want %03h", name, got, want);
        end
    endtask

    initial begin
        logic [7:0] p;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = cyc;
        chk("reset_state", {mode, led}, 10'h000);
        prev   = {mode, led};
        mon_en = 1'b1;

        // 3-cycle glitch on btnC: no event, outputs stay at reset values.
        wait_edge(4);  btnC = 1'b1;
        wait_edge(7);  btnC = 1'b0;

        // btnC held 20 cycles: one mode change (edge 27), then left rotation
        // every 16 cycles from edge 43 through a full wrap back to 0x01.
        exp_push(2'd1, 8'h00);
        exp_push(2'd1, 8'h01);
        p = 8'h01;
        repeat (8) begin
            p = {p[6:0], p[7]};
            exp_push(2'd1, p);
        end
        wait_edge(20);  btnC = 1'b1;
        wait_edge(40);  btnC = 1'b0;

        // btnR sets dir=right at edge 165; the tick at 171 turns 0x01 into 0x80.
        exp_push(2'd1, 8'h80);
        wait_edge(158); btnR = 1'b1;
        wait_edge(166); btnR = 1'b0;

        // Five btnU presses (events 180..228): speed saturates at 3. Ticks at
        // 188,196,200, then every 2 cycles; ticks at 204,216,228 lose to the
        // button event. 22 effective right rotations up to edge 246.
        p = 8'h80;
        repeat (22) begin
            p = {p[0], p[7:1]};
            exp_push(2'd1, p);
        end
        for (int i = 0; i < 5; i++) begin
            wait_edge(173 + 12 * i); btnU = 1'b1;
            wait_edge(181 + 12 * i); btnU = 1'b0;
        end

        // BLINK at edge 248 (pattern 0x02), blink phase toggles every 2 cycles.
        exp_push(2'd2, 8'h02);
        exp_push(2'd2, 8'h00);
        exp_push(2'd2, 8'h02);
        exp_push(2'd2, 8'h00);
        exp_push(2'd2, 8'h02);
        exp_push(2'd2, 8'h00);
        wait_edge(241); btnC = 1'b1;
        wait_edge(249); btnC = 1'b0;

        // COUNT at edge 260: count steps every 2 cycles, 0xFF wraps to 0x00.
        exp_push(2'd3, 8'h00);
        for (int j = 1; j <= 256; j++) exp_push(2'd3, 8'(j));
        wait_edge(253); btnC = 1'b1;
        wait_edge(261); btnC = 1'b0;

        // btnR in COUNT clears count at edge 786, counting resumes.
        for (int j = 1; j <= 6; j++) exp_push(2'd3, 8'(j));
        exp_push(2'd3, 8'h00);
        for (int j = 1; j <= 4; j++) exp_push(2'd3, 8'(j));
        wait_edge(779); btnR = 1'b1;
        wait_edge(787); btnR = 1'b0;

        // Asynchronous reset mid-count, asserted between clock edges.
        exp_push(2'd0, 8'h00);
        wait_edge(795);
        #6 rst_n = 1'b0;
        #1 chk("async_reset", {mode, led}, 10'h000);
        wait_edge(798); rst_n = 1'b1;
        base = cyc;

        // btnC with btnR together in STATIC: mode advances, pattern untouched,
        // then one left-rotation tick at edge 29 before a second reset.
        exp_push(2'd1, 8'h00);
        exp_push(2'd1, 8'h01);
        exp_push(2'd1, 8'h02);
        exp_push(2'd0, 8'h00);
        wait_edge(6);  btnC = 1'b1; btnR = 1'b1;
        wait_edge(14); btnC = 1'b0; btnR = 1'b0;

        // btnC held across reset and its release: must not fire.
        wait_edge(37); btnC = 1'b1; rst_n = 1'b0;
        wait_edge(40); rst_n = 1'b1;
        base = cyc;
        wait_edge(20); btnC = 1'b0;

        // btnL held 40 cycles in STATIC.
`ifdef BTN_REPEAT_EN
        exp_push(2'd0, 8'h02);
        exp_push(2'd0, 8'h04);
        exp_push(2'd0, 8'h08);
        exp_push(2'd0, 8'h10);
        exp_push(2'd0, 8'h20);
`else
        exp_push(2'd0, 8'h02);
`endif
        wait_edge(30); btnL = 1'b1;
        wait_edge(70); btnL = 1'b0;

        wait_edge(100);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending entries want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
